// File: rtl/fip_seq_div.sv
// Sequential signed Q(INT_BITS).(FRAC_BITS) divider, radix-2 restoring, one quotient bit per clock.
// Define FIP_DIV_SATURATE_EN to clamp overflowed quotients instead of wrapping them.
module fip_seq_div #(
  parameter int INT_BITS  = 16,
  parameter int FRAC_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0] dividend,
  input  logic [INT_BITS+FRAC_BITS-1:0] divisor,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] quotient,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          div_by_zero
);

  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int N  = W + FRAC_BITS;
  localparam int CW = $clog2(N);

  localparam logic [N-1:0] QLIM = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXW = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINW = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic          sign;
  logic          dvd_neg;
  logic          dvd_nz;
  logic          dz;
  logic [N-1:0]  numer;
  logic [W-1:0]  denom;
  logic [W-1:0]  rem;
  logic [N-1:0]  q_mag;
  logic [CW-1:0] cnt;

  logic [W:0]    dvd_ext;
  logic [W:0]    dvs_ext;
  logic [W-1:0]  dvd_abs;
  logic [W-1:0]  dvs_abs;
  logic [W:0]    rem_sh;
  logic          rem_ge;
  logic          q_ovf;
  logic [W-1:0]  q_wrap;
  logic [W-1:0]  q_res;

  // Sign-extended negation keeps |-2^(W-1)| = 2^(W-1) exact; it still fits W unsigned bits.
  always_comb begin
    dvd_ext = {dividend[W-1], dividend};
    dvs_ext = {divisor[W-1], divisor};
    dvd_abs = dividend[W-1] ? W'(-dvd_ext) : dividend;
    dvs_abs = divisor[W-1]  ? W'(-dvs_ext) : divisor;
  end

  always_comb begin
    rem_sh = {rem, numer[N-1]};
    rem_ge = (rem_sh >= {1'b0, denom});
  end

  // The negative range reaches one step further than the positive one.
  always_comb begin
    q_ovf  = sign ? (q_mag > QLIM) : (q_mag >= QLIM);
    q_wrap = sign ? -q_mag[W-1:0] : q_mag[W-1:0];
`ifdef FIP_DIV_SATURATE_EN
    q_res  = q_ovf ? (sign ? MINW : MAXW) : q_wrap;
`else
    q_res  = q_wrap;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sign        <= 1'b0;
      dvd_neg     <= 1'b0;
      dvd_nz      <= 1'b0;
      dz          <= 1'b0;
      numer       <= '0;
      denom       <= '0;
      rem         <= '0;
      q_mag       <= '0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= dividend[W-1] ^ divisor[W-1];
            dvd_neg  <= dividend[W-1];
            dvd_nz   <= (dividend != '0);
            dz       <= (divisor == '0);
            numer    <= {dvd_abs, {FRAC_BITS{1'b0}}};
            denom    <= dvs_abs;
            rem      <= '0;
            q_mag    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= (divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          numer <= numer << 1;
          rem   <= rem_ge ? W'(rem_sh - {1'b0, denom}) : rem_sh[W-1:0];
          q_mag <= {q_mag[N-2:0], rem_ge};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N-1)) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            quotient    <= dvd_nz ? (dvd_neg ? MINW : MAXW) : '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_res;
            overflow    <= q_ovf;
            underflow   <= dvd_nz && (q_mag == '0);
            div_by_zero <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fip_seq_div.sv
// Self-checking bench for fip_seq_div at the default Q16.16 format.
// Expected results are queued at accept time and compared when the DUT hands a result over.
module tb_fip_seq_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  always #5 clk = ~clk;

  fip_seq_div #(.INT_BITS(16), .FRAC_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .overflow(overflow),
    .underflow(underflow), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ov;
    logic        un;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic        ov;
    logic        un;
    logic        dz;
    int          acc;
    int          id;
  } exp_t;

`ifdef FIP_DIV_SATURATE_EN
  localparam logic [31:0] Q_OVF_A = 32'h7FFFFFFF;
  localparam logic [31:0] Q_OVF_B = 32'h7FFFFFFF;
`else
  localparam logic [31:0] Q_OVF_A = 32'h80000000;
  localparam logic [31:0] Q_OVF_B = 32'hFF000000;
`endif
  localparam longint QMAX = 64'sd2147483647;
  localparam longint QMIN = -64'sd2147483648;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   results = 0;
  int   issued = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t   v;
    longint sa, sd, qq;
    v.a = a;
    v.b = b;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    if (sd == 0) begin
      v.dz = 1'b1;
      v.ov = 1'b0;
      v.un = 1'b0;
      v.q  = (sa > 0) ? 32'h7FFFFFFF : (sa < 0) ? 32'h80000000 : 32'h0;
    end else begin
      qq   = (sa * 65536) / sd;
      v.dz = 1'b0;
      v.ov = (qq > QMAX) || (qq < QMIN);
      v.un = (sa != 0) && (qq == 0);
`ifdef FIP_DIV_SATURATE_EN
      if (qq > QMAX)      v.q = 32'h7FFFFFFF;
      else if (qq < QMIN) v.q = 32'h80000000;
      else                v.q = qq[31:0];
`else
      v.q = qq[31:0];
`endif
    end
    return v;
  endfunction

  task automatic issue(input vec_t v);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL accept_timeout[%0d] got=in_ready_low expected=in_ready_high", issued);
      return;
    end
    dividend = v.a;
    divisor  = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    e = '{q: v.q, ov: v.ov, un: v.un, dz: v.dz, acc: cyc, id: issued};
    sbq.push_back(e);
    issued++;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d pending expected=0", sbq.size());
    end
  endtask

  // Monitor: latency when out_valid first rises, full result on the handshake cycle.
  initial begin
    logic seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!out_valid) begin
        seen = 1'b0;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL spurious_out_valid got=1 expected=0");
          end else begin
            chk($sformatf("latency[%0d]", sbq[0].id), 32'(cyc - sbq[0].acc),
                sbq[0].dz ? 32'd1 : 32'd49);
          end
        end
        if (out_ready && sbq.size() != 0) begin
          e = sbq.pop_front();
          chk($sformatf("quotient[%0d]", e.id), quotient, e.q);
          chk($sformatf("overflow[%0d]", e.id), 32'(overflow), 32'(e.ov));
          chk($sformatf("underflow[%0d]", e.id), 32'(underflow), 32'(e.un));
          chk($sformatf("div_by_zero[%0d]", e.id), 32'(div_by_zero), 32'(e.dz));
          results++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[12];
    logic [31:0] hold_q;
    int          n;

    tbl[0]  = '{32'h00010000, 32'h00020000, 32'h00008000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFFD0000, 32'h00020000, 32'hFFFE8000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{32'h80000000, 32'hFFFF0000, Q_OVF_A,      1'b1, 1'b0, 1'b0};
    tbl[3]  = '{32'h7FFF0000, 32'h00000100, Q_OVF_B,      1'b1, 1'b0, 1'b0};
    tbl[4]  = '{32'h00000001, 32'h00020000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{32'h00010000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{32'hFFFF0000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{32'h00000000, 32'h00050000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'h80000000, 32'h80000000, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00010000, 1'b0, 1'b0, 1'b0};

    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", quotient, 32'h0);
    chk("reset_flags", {29'b0, overflow, underflow, div_by_zero}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) issue(tbl[i]);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 1) == 1) b = -b;
      issue(model(a, b));
    end
    wait_drain();

    // Backpressure: result must hold and in_valid pulses must be ignored.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue('{32'h00030000, 32'h00010000, 32'h00030000, 1'b0, 1'b0, 1'b0});
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_rise", 32'(out_valid), 32'd1);
    hold_q = 32'h00030000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid[%0d]", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_quot[%0d]", i), quotient, hold_q);
      chk($sformatf("bp_in_ready[%0d]", i), 32'(in_ready), 32'd0);
      in_valid = i[0];
      dividend = $urandom;
      divisor  = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue('{32'hFFFE0000, 32'h00040000, 32'hFFFF8000, 1'b0, 1'b0, 1'b0});
    issue('{32'h00090000, 32'h00030000, 32'h00030000, 1'b0, 1'b0, 1'b0});
    wait_drain();
    chk("result_count", 32'(results), 32'(issued));

    // Reset in the middle of CALC discards the operation and clears the outputs at once.
    issue('{32'h00050000, 32'h00020000, 32'h00028000, 1'b0, 1'b0, 1'b0});
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_quotient", quotient, 32'h0);
    chk("mid_rst_flags", {29'b0, overflow, underflow, div_by_zero}, 32'h0);
    if (sbq.size() != 0) void'(sbq.pop_front());
    issued--;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue('{32'h00070000, 32'hFFFE0000, 32'hFFFC8000, 1'b0, 1'b0, 1'b0});
    wait_drain();
    chk("final_result_count", 32'(results), 32'(issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
